axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 64, AXI address width.
REQ-002 The block SHALL have parameter DataWidth, default 64, AXI data width (fixed: only 64 supported).
REQ-003 The block SHALL have parameter IdWidth, default 4, AXI ID width.
REQ-004 The block SHALL have parameter MemBase, default 64'h8000_0000, base byte address of the served region.
REQ-005 The block SHALL have parameter MemWords, default 1024, number of 64-bit words in the region (power of two).
REQ-006 Ports SHALL be: clk_i in 1, single clock; rst_ni in 1, asynchronous active-low reset.
REQ-007 AW: aw_valid_i in 1; aw_ready_o out 1; aw_id_i in IdWidth; aw_addr_i in AddrWidth; aw_len_i in 8; aw_size_i in 3; aw_burst_i in 2.
REQ-008 W: w_valid_i in 1; w_ready_o out 1; w_data_i in 64; w_strb_i in 8; w_last_i in 1.
REQ-009 B: b_valid_o out 1; b_ready_i in 1; b_id_o out IdWidth; b_resp_o out 2.
REQ-010 AR: ar_valid_i in 1; ar_ready_o out 1; ar_id_i in IdWidth; ar_addr_i in AddrWidth; ar_len_i in 8; ar_size_i in 3; ar_burst_i in 2.
REQ-011 R: r_valid_o out 1; r_ready_i in 1; r_id_o out IdWidth; r_data_o out 64; r_resp_o out 2; r_last_o out 1.

Function
REQ-012 The block SHALL be an AXI4 subordinate serving one transaction at a time, backed by an internal MemWords x 64 register array.
REQ-013 FSM states SHALL be IDLE, WRITE, WRESP, READ.
REQ-014 In IDLE, aw_ready_o and ar_ready_o SHALL be high only when no transaction is in progress; all other ready/valid outputs low.
REQ-015 Simultaneous aw_valid_i and ar_valid_i in IDLE: accept the channel not served last; after reset the first tie SHALL go to read.
REQ-016 AW handshake SHALL latch id, word address, len, error flag and move to WRITE; AR handshake SHALL latch the same and move to READ.
REQ-017 Error flag SHALL be set if burst != INCR (2'b01), size != 3, or any beat address falls outside [MemBase, MemBase+8*MemWords).
REQ-018 In WRITE, w_ready_o SHALL be high from the cycle after the AW handshake; each W handshake SHALL write bytes enabled by w_strb_i (if no error) and increment the word address by one.
REQ-019 WRITE SHALL exit to WRESP on the handshake of beat len+1; w_last_i SHALL be ignored for sequencing.
REQ-020 In WRESP, b_valid_o SHALL assert the cycle after the last W handshake, b_id_o = latched id, b_resp_o = 2'b00 OKAY or 2'b10 SLVERR on error; hold until b_ready_i, then IDLE.
REQ-021 In READ, r_valid_o SHALL assert the cycle after the AR handshake with r_data_o = array word at current address (0 on error), r_resp_o OKAY/SLVERR, r_id_o = latched id.
REQ-022 r_last_o SHALL be high only on beat len+1; after its handshake the FSM SHALL return to IDLE.
REQ-023 All R and B outputs SHALL remain stable while valid and not ready.
REQ-024 Array index SHALL be (addr - MemBase) >> 3, truncated to log2(MemWords) bits; no wrap across region end (caught by REQ-017).
REQ-025 Error bursts SHALL still consume/produce exactly len+1 beats.
REQ-026 A read of an address written earlier in a completed transaction SHALL return the written data.

Reset
REQ-027 On rst_ni low, FSM SHALL go to IDLE immediately; aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o SHALL be 0; b_id_o, b_resp_o, r_id_o, r_data_o, r_resp_o SHALL be 0; arbitration priority SHALL be read.
REQ-028 Reset mid-burst SHALL abort the transaction without response; array contents SHALL be unspecified after reset.

Verification
REQ-029 Write 0x8000_0000, len=1, data {0x1111, 0x2222}, strb 0xFF, id 3 -> B OKAY id 3 one cycle after beat 2; read same len=1 -> R {0x1111, 0x2222}, r_last on beat 2, id 3.
REQ-030 Write 0x8000_0010 data 0xFFFF_FFFF_FFFF_FFFF, strb 0x0F over prior 0 -> read returns 0x0000_0000_FFFF_FFFF.
REQ-031 AR to 0x1_0000, len=3 -> 4 R beats, data 0, SLVERR, r_last only on 4th.
REQ-032 aw_valid_i and ar_valid_i together after reset -> read accepted first; next tie -> write accepted.
REQ-033 r_ready_i low 5 cycles mid-burst -> r_valid_o, r_data_o, r_last_o held stable; no beat lost or duplicated.
REQ-034 rst_ni low during WRITE beat 2 of 4 -> all valids/readies 0 immediately; new AR after release served normally.

Source files
------------

// File: rtl/axi_mem_if.sv
// axi_mem_if: AXI4 channel bundle between a manager and the memory responder
interface axi_mem_if #(
   parameter int AddrWidth = 64,
   parameter int IdWidth   = 4
);
   logic                 aw_valid, aw_ready;
   logic [IdWidth-1:0]   aw_id;
   logic [AddrWidth-1:0] aw_addr;
   logic [7:0]           aw_len;
   logic [2:0]           aw_size;
   logic [1:0]           aw_burst;
   logic                 w_valid, w_ready;
   logic [63:0]          w_data;
   logic [7:0]           w_strb;
   logic                 w_last;
   logic                 b_valid, b_ready;
   logic [IdWidth-1:0]   b_id;
   logic [1:0]           b_resp;
   logic                 ar_valid, ar_ready;
   logic [IdWidth-1:0]   ar_id;
   logic [AddrWidth-1:0] ar_addr;
   logic [7:0]           ar_len;
   logic [2:0]           ar_size;
   logic [1:0]           ar_burst;
   logic                 r_valid, r_ready;
   logic [IdWidth-1:0]   r_id;
   logic [63:0]          r_data;
   logic [1:0]           r_resp;
   logic                 r_last;

   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_id, b_resp,
      input  b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      output ar_ready,
      output r_valid, r_id, r_data, r_resp, r_last,
      input  r_ready
   );

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_id, b_resp,
      output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      input  ar_ready,
      input  r_valid, r_id, r_data, r_resp, r_last,
      output r_ready
   );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-outstanding AXI4 subordinate backed by a MemWords x 64 register array
module axi_mem_responder #(
   parameter int          AddrWidth = 64,
   parameter int          DataWidth = 64,
   parameter int          IdWidth   = 4,
   parameter logic [63:0] MemBase   = 64'h8000_0000,
   parameter int          MemWords  = 1024
) (
   input logic      clk_i,
   input logic      rst_ni,
   axi_mem_if.slave bus
);
   localparam int IdxW = $clog2(MemWords);
   localparam logic [AddrWidth:0] Base = (AddrWidth+1)'(MemBase);
   localparam logic [AddrWidth:0] Top  = Base + (AddrWidth+1)'(64'(MemWords) * 64'd8);

   typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

   state_t             state, state_n;
   logic [IdWidth-1:0] id_q;
   logic [IdxW-1:0]    idx;
   logic [7:0]         len_q, cnt;
   logic               err, last_rd;
   logic               aw_hs, ar_hs, w_hs, r_hs;
   logic [63:0]        mem [MemWords];
   logic               unused_w_last;

   assign unused_w_last = bus.w_last;

   // Every beat of the burst, from the aligned start to the last one, must sit inside the region
   function automatic logic bad(input logic [AddrWidth-1:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
      logic [AddrWidth:0] a, e;
      a = {1'b0, addr} & ~(AddrWidth+1)'(7);
      e = a + ((AddrWidth+1)'(len) << 3) + (AddrWidth+1)'(8);
      return burst != 2'b01 || size != 3'd3 || {1'b0, addr} < Base || e > Top;
   endfunction

   always_comb begin
      bus.aw_ready = rst_ni && state == IDLE && !(bus.ar_valid && !last_rd);
      bus.ar_ready = rst_ni && state == IDLE && !(bus.aw_valid && last_rd);
      bus.w_ready  = state == WRITE;
      bus.b_valid  = state == WRESP;
      bus.b_id     = bus.b_valid ? id_q : '0;
      bus.b_resp   = bus.b_valid && err ? 2'b10 : 2'b00;
      bus.r_valid  = state == READ;
      bus.r_id     = bus.r_valid ? id_q : '0;
      bus.r_data   = bus.r_valid && !err ? mem[idx] : '0;
      bus.r_resp   = bus.r_valid && err ? 2'b10 : 2'b00;
      bus.r_last   = bus.r_valid && cnt == len_q;
      aw_hs        = bus.aw_valid && bus.aw_ready;
      ar_hs        = bus.ar_valid && bus.ar_ready;
      w_hs         = bus.w_valid && bus.w_ready;
      r_hs         = bus.r_valid && bus.r_ready;
      state_n      = state;
      case (state)
         IDLE:    state_n = ar_hs ? READ : aw_hs ? WRITE : IDLE;
         WRITE:   state_n = w_hs && cnt == len_q ? WRESP : WRITE;
         WRESP:   state_n = bus.b_ready ? IDLE : WRESP;
         default: state_n = r_hs && bus.r_last ? IDLE : READ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         id_q    <= '0;
         idx     <= '0;
         len_q   <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         last_rd <= 1'b0;
      end else begin
         state <= state_n;
         if (ar_hs) begin
            id_q    <= bus.ar_id;
            idx     <= IdxW'((bus.ar_addr - AddrWidth'(MemBase)) >> 3);
            len_q   <= bus.ar_len;
            cnt     <= '0;
            err     <= bad(bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst);
            last_rd <= 1'b1;
         end else if (aw_hs) begin
            id_q    <= bus.aw_id;
            idx     <= IdxW'((bus.aw_addr - AddrWidth'(MemBase)) >> 3);
            len_q   <= bus.aw_len;
            cnt     <= '0;
            err     <= bad(bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst);
            last_rd <= 1'b0;
         end else if (w_hs || r_hs) begin
            idx <= idx + IdxW'(1);
            cnt <= cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_hs && !err)
         for (int b = 0; b < 8; b++)
            if (bus.w_strb[b]) mem[idx][8*b +: 8] <= bus.w_data[8*b +: 8];
   end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed table of AXI transactions plus tie, backpressure and reset sequences
module tb_axi_mem_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   axi_mem_if #(.AddrWidth(64), .IdWidth(4)) bus ();

   axi_mem_responder dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   typedef struct {
      bit          wr;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [3:0]  id;
      logic [63:0] d0, inc;
      logic [7:0]  strb;
      logic [1:0]  resp;
      int          stall;
      bit          chkd;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic xact(input int k, input vec_t v);
      int n;
      logic [63:0] exp;
      if (v.wr) begin
         bus.aw_id = v.id; bus.aw_addr = v.addr; bus.aw_len = v.len;
         bus.aw_size = v.size; bus.aw_burst = v.burst; bus.aw_valid = 1'b1;
         #1;
         n = 0;
         while (!bus.aw_ready && n < 20) begin @(posedge clk); #1; n++; end
         chk($sformatf("v%0d_aw_timeout", k), 64'(n < 20), 64'd1);
         @(posedge clk); #1;
         bus.aw_valid = 1'b0;
         chk($sformatf("v%0d_w_ready", k), 64'(bus.w_ready), 64'd1);
         for (int i = 0; i <= int'(v.len); i++) begin
            bus.w_valid = 1'b1;
            bus.w_data = v.d0 + 64'(i) * v.inc;
            bus.w_strb = v.strb;
            bus.w_last = (i == int'(v.len));
            #1;
            n = 0;
            while (!bus.w_ready && n < 20) begin @(posedge clk); #1; n++; end
            chk($sformatf("v%0d_w%0d_timeout", k, i), 64'(n < 20), 64'd1);
            @(posedge clk); #1;
         end
         bus.w_valid = 1'b0; bus.w_last = 1'b0;
         chk($sformatf("v%0d_b_valid", k), 64'(bus.b_valid), 64'd1);
         chk($sformatf("v%0d_b_id", k), 64'(bus.b_id), 64'(v.id));
         chk($sformatf("v%0d_b_resp", k), 64'(bus.b_resp), 64'(v.resp));
         bus.b_ready = 1'b1;
         @(posedge clk); #1;
         bus.b_ready = 1'b0;
         chk($sformatf("v%0d_b_done", k), 64'(bus.b_valid), 64'd0);
      end else begin
         bus.ar_id = v.id; bus.ar_addr = v.addr; bus.ar_len = v.len;
         bus.ar_size = v.size; bus.ar_burst = v.burst; bus.ar_valid = 1'b1;
         #1;
         n = 0;
         while (!bus.ar_ready && n < 20) begin @(posedge clk); #1; n++; end
         chk($sformatf("v%0d_ar_timeout", k), 64'(n < 20), 64'd1);
         @(posedge clk); #1;
         bus.ar_valid = 1'b0;
         for (int i = 0; i <= int'(v.len); i++) begin
            exp = v.d0 + 64'(i) * v.inc;
            chk($sformatf("v%0d_r%0d_valid", k, i), 64'(bus.r_valid), 64'd1);
            if (v.chkd) chk($sformatf("v%0d_r%0d_data", k, i), bus.r_data, exp);
            chk($sformatf("v%0d_r%0d_resp", k, i), 64'(bus.r_resp), 64'(v.resp));
            chk($sformatf("v%0d_r%0d_id", k, i), 64'(bus.r_id), 64'(v.id));
            chk($sformatf("v%0d_r%0d_last", k, i), 64'(bus.r_last), 64'(i == int'(v.len)));
            if (i == 1)
               for (int s = 0; s < v.stall; s++) begin
                  @(posedge clk); #1;
                  chk($sformatf("v%0d_stall%0d_valid", k, s), 64'(bus.r_valid), 64'd1);
                  chk($sformatf("v%0d_stall%0d_data", k, s), bus.r_data, exp);
                  chk($sformatf("v%0d_stall%0d_last", k, s), 64'(bus.r_last), 64'(i == int'(v.len)));
               end
            bus.r_ready = 1'b1;
            @(posedge clk); #1;
            bus.r_ready = 1'b0;
         end
         chk($sformatf("v%0d_r_done", k), 64'(bus.r_valid), 64'd0);
      end
   endtask

   function automatic logic [63:0] ctl();
      return 64'({bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1, 64'h8000_0000, 8'd1, 2'b01, 3'd3, 4'd3,  64'h1111, 64'h1111, 8'hFF, 2'b00, 0, 1};
      vecs[1]  = '{0, 64'h8000_0000, 8'd1, 2'b01, 3'd3, 4'd3,  64'h1111, 64'h1111, 8'hFF, 2'b00, 0, 1};
      vecs[2]  = '{1, 64'h8000_0010, 8'd0, 2'b01, 3'd3, 4'd1,  64'h0, 64'h0, 8'hFF, 2'b00, 0, 1};
      vecs[3]  = '{1, 64'h8000_0010, 8'd0, 2'b01, 3'd3, 4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F, 2'b00, 0, 1};
      vecs[4]  = '{0, 64'h8000_0010, 8'd0, 2'b01, 3'd3, 4'd5,  64'h0000_0000_FFFF_FFFF, 64'h0, 8'hFF, 2'b00, 0, 1};
      vecs[5]  = '{0, 64'h0001_0000, 8'd3, 2'b01, 3'd3, 4'd7,  64'h0, 64'h0, 8'hFF, 2'b10, 0, 1};
      vecs[6]  = '{1, 64'h8000_0000, 8'd0, 2'b00, 3'd3, 4'd4,  64'hDEAD, 64'h0, 8'hFF, 2'b10, 0, 1};
      vecs[7]  = '{0, 64'h8000_0000, 8'd0, 2'b01, 3'd2, 4'd8,  64'h0, 64'h0, 8'hFF, 2'b10, 0, 1};
      vecs[8]  = '{1, 64'h8000_1FF8, 8'd1, 2'b01, 3'd3, 4'd9,  64'hBEEF, 64'h1, 8'hFF, 2'b10, 0, 1};
      vecs[9]  = '{1, 64'h8000_1FF8, 8'd0, 2'b01, 3'd3, 4'hA,  64'hABCD, 64'h0, 8'hFF, 2'b00, 0, 1};
      vecs[10] = '{0, 64'h8000_1FF8, 8'd0, 2'b01, 3'd3, 4'hB,  64'hABCD, 64'h0, 8'hFF, 2'b00, 0, 1};
      vecs[11] = '{0, 64'h8000_0000, 8'd0, 2'b01, 3'd3, 4'hC,  64'h1111, 64'h0, 8'hFF, 2'b00, 0, 1};
      vecs[12] = '{0, 64'h7FFF_FFF8, 8'd0, 2'b01, 3'd3, 4'hD,  64'h0, 64'h0, 8'hFF, 2'b10, 0, 1};
      vecs[13] = '{1, 64'h8000_0100, 8'd2, 2'b01, 3'd3, 4'hE,  64'hA0, 64'h10, 8'hFF, 2'b00, 0, 1};
      vecs[14] = '{0, 64'h8000_0100, 8'd2, 2'b01, 3'd3, 4'hF,  64'hA0, 64'h10, 8'hFF, 2'b00, 5, 1};
      vecs[15] = '{0, 64'h8000_0008, 8'd0, 2'b01, 3'd3, 4'd0,  64'h2222, 64'h0, 8'hFF, 2'b00, 0, 1};

      bus.aw_valid = 1'b1; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
      bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
      bus.b_ready = 1'b0; bus.r_ready = 1'b0;
      bus.ar_valid = 1'b1; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
      #12;
      chk("reset_ctl", ctl(), 64'd0);
      chk("reset_ids", 64'({bus.b_id, bus.b_resp, bus.r_id, bus.r_resp}), 64'd0);
      chk("reset_rdata", bus.r_data, 64'd0);
      bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First tie after reset goes to read, the next tie to write
      bus.aw_valid = 1'b1; bus.aw_addr = 64'h8000_0010; bus.aw_len = 8'd0; bus.aw_size = 3'd3;
      bus.aw_burst = 2'b01; bus.aw_id = 4'd9;
      bus.ar_valid = 1'b1; bus.ar_addr = 64'h8000_0000; bus.ar_len = 8'd0; bus.ar_size = 3'd3;
      bus.ar_burst = 2'b01; bus.ar_id = 4'd6;
      #1;
      chk("tie1_ar_ready", 64'(bus.ar_ready), 64'd1);
      chk("tie1_aw_ready", 64'(bus.aw_ready), 64'd0);
      @(posedge clk); #1;
      bus.ar_valid = 1'b0;
      chk("tie1_r_valid", 64'(bus.r_valid), 64'd1);
      chk("tie1_r_id", 64'(bus.r_id), 64'd6);
      chk("tie1_r_last", 64'(bus.r_last), 64'd1);
      chk("tie1_busy_aw_ready", 64'(bus.aw_ready), 64'd0);
      bus.r_ready = 1'b1;
      @(posedge clk); #1;
      bus.r_ready = 1'b0;
      bus.ar_valid = 1'b1;
      #1;
      chk("tie2_aw_ready", 64'(bus.aw_ready), 64'd1);
      chk("tie2_ar_ready", 64'(bus.ar_ready), 64'd0);
      @(posedge clk); #1;
      bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
      chk("tie2_w_ready", 64'(bus.w_ready), 64'd1);
      bus.w_valid = 1'b1; bus.w_data = 64'h0; bus.w_strb = 8'hFF; bus.w_last = 1'b1;
      @(posedge clk); #1;
      bus.w_valid = 1'b0; bus.w_last = 1'b0;
      chk("tie2_b_valid", 64'(bus.b_valid), 64'd1);
      chk("tie2_b_id", 64'(bus.b_id), 64'd9);
      bus.b_ready = 1'b1;
      @(posedge clk); #1;
      bus.b_ready = 1'b0;

      for (int k = 0; k < 16; k++) xact(k, vecs[k]);

      // Reset lands during beat 2 of a 4-beat write
      bus.aw_valid = 1'b1; bus.aw_addr = 64'h8000_0200; bus.aw_len = 8'd3; bus.aw_size = 3'd3;
      bus.aw_burst = 2'b01; bus.aw_id = 4'd2;
      #1;
      @(posedge clk); #1;
      bus.aw_valid = 1'b0;
      chk("rstw_w_ready", 64'(bus.w_ready), 64'd1);
      bus.w_valid = 1'b1; bus.w_data = 64'h1; bus.w_strb = 8'hFF;
      @(posedge clk); #1;
      bus.w_data = 64'h2;
      #2;
      rst_n = 1'b0;
      bus.ar_valid = 1'b1;
      #1;
      chk("rstw_ctl", ctl(), 64'd0);
      chk("rstw_ids", 64'({bus.b_id, bus.b_resp, bus.r_id, bus.r_resp}), 64'd0);
      bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      xact(100, '{0, 64'h8000_0000, 8'd1, 2'b01, 3'd3, 4'hA, 64'h0, 64'h0, 8'hFF, 2'b00, 0, 0});
      xact(101, '{1, 64'h8000_0300, 8'd0, 2'b01, 3'd3, 4'h5, 64'h55AA, 64'h0, 8'hFF, 2'b00, 0, 1});
      xact(102, '{0, 64'h8000_0300, 8'd0, 2'b01, 3'd3, 4'h6, 64'h55AA, 64'h0, 8'hFF, 2'b00, 0, 1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
